axi_slave_rd_ctrl: RTL and testbench
====================================

# axi_slave_rd_ctrl

AXI4 read-channel controller for the AXI slave. Accepts one read-address (AR) request at a time, expands it into per-beat reads on the simple slave memory read port (`oen`/`add_rd`/`dat_rd`), and returns the data on the R channel with full `rready` back-pressure. A 2-entry output buffer decouples memory read latency from R-channel stalls. The block sits between the AXI read interface and the memory read port, and drives only the read side of the simple slave port.

## Interface

- `DATA_WIDTH`, 64, width of memory data and `rdata`
- `ADDR_WIDTH`, 8, memory word-address width; also the `araddr` width
- `ID_WIDTH`, 4, AXI ID width
- `clk` input 1 clock; all logic on the rising edge
- `rst_n` input 1 asynchronous active-low reset
- `arvalid` input 1 AR valid
- `arready` output 1 AR ready
- `araddr` input ADDR_WIDTH start word address
- `arlen` input 8 beats minus 1
- `arburst` input 2 burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- `arid` input ID_WIDTH transaction ID
- `rvalid` output 1 R valid
- `rready` input 1 R ready
- `rdata` output DATA_WIDTH read data
- `rresp` output 2 response: 00 OKAY, 10 SLVERR
- `rlast` output 1 last beat of the burst
- `rid` output ID_WIDTH, equal to the `arid` of the burst
- `oen` output 1 memory read strobe
- `add_rd` output ADDR_WIDTH memory read address
- `dat_rd` input DATA_WIDTH memory read data, valid the cycle after `oen`

## Operation

- FSM states are IDLE and BURST. Reset state is IDLE.
- IDLE: `arready`=1. An AR handshake latches addr/len/burst/id, loads the beat counter with `arlen`, and moves to BURST.
- BURST: `arready`=0. One beat is issued per cycle when a credit is available. The FSM returns to IDLE in the cycle after the last beat is issued, so the next AR can be accepted while earlier beats drain.
- Credit: issue is allowed when (buffer entries + reads in flight) < 2, or when it equals 2 and an R handshake occurs in the same cycle.
- Issue: `oen`=1, `add_rd` = current address. The beat's error flag, last flag and ID are tagged into the in-flight slot.
- Address update per issued beat:
  - FIXED: unchanged.
  - INCR: +1, wrapping modulo 2^ADDR_WIDTH.
  - WRAP: +1 within the aligned window of (arlen+1) words. Low log2(arlen+1) bits wrap; upper bits are held.
- Error bursts produce arlen+1 beats with `rresp`=10, `rdata`=0, and no `oen` assertion. The beats still consume credits and keep 1 cycle of latency. Error cases:
  - `arburst`=11.
  - WRAP with arlen+1 not in {2,4,8,16}.
  - WRAP when the macro is absent.
- Buffer: 2-entry FIFO of {data, resp, last, id}. Write happens the cycle after issue, capturing `dat_rd` (or 0 for error beats). The head entry drives the R channel.
- `rlast`=1 only on beat arlen of each burst. arlen=0 gives a single beat with `rlast`=1.
- Reset, including mid-burst, asynchronously clears the FSM, counters, in-flight tags and buffer. Pending beats are discarded.
- Reset values:
  - `arready`=0 while `rst_n`=0, then 1 from the first cycle after release.
  - `rvalid`=0, `rdata`=0, `rresp`=0, `rlast`=0, `rid`=0, `oen`=0, `add_rd`=0.

## Timing

- Cycle 0 is the AR handshake. First `oen` is in cycle 1. `dat_rd` is sampled at the end of cycle 2. First `rvalid` is in cycle 3.
- With `rready` held at 1, throughput is 1 beat/cycle. A burst of N beats shows `rvalid` in cycles 3..N+2.
- Back-to-back: a new AR is accepted in cycle N+1 after an N-beat burst. Its first `oen` is in cycle N+2, with no bubble on R.
- `rready`=0: `rvalid`, `rdata`, `rresp`, `rlast` and `rid` are held stable until the handshake. `oen` stops once the credit reaches 0; no read is ever dropped or overwritten.
- `add_rd` holds its last value while `oen`=0.
- `arready` is a registered output. It never depends combinationally on `arvalid`.

## Configuration

- `AXI_RD_WRAP_EN` defined: WRAP bursts are supported as described above.
- `AXI_RD_WRAP_EN` undefined: the wrap address logic is removed, and every WRAP request is answered as an error burst (arlen+1 SLVERR beats, no `oen`).

## Test plan

- Single beat: AR addr 0x10, len 0, INCR, id 3 -> one `oen` with `add_rd`=0x10 in cycle 1; `rvalid` in cycle 3 with mem[0x10], OKAY, `rlast`=1, `rid`=3.
- INCR wrap-around: addr 0xFE, len 3 -> `add_rd` sequence 0xFE, 0xFF, 0x00, 0x01; `rlast` on the 4th beat only.
- WRAP (macro on): addr 0x06, len 3 -> `add_rd` 0x06, 0x07, 0x04, 0x05. With the macro off -> 4 SLVERR beats and no `oen`.
- Back-pressure: len 7 INCR with `rready` toggling 1,0,0,1,... -> all 8 beats in order with correct data; R outputs stable while stalled; in-flight+buffer count never exceeds 2.
- Reserved/illegal: `arburst`=11, len 2 -> 3 beats with `rresp`=10, `rdata`=0, `oen` never asserted. WRAP with len 2 -> same.
- Back-to-back and reset: two len-3 bursts (id 1, id 2) -> 8 contiguous R beats with matching `rid`. Assert `rst_n` low mid-burst -> all outputs at reset values; no stale beats after release.

Source files
------------

// File: rtl/axi_slave_rd_if.sv
// axi_slave_rd_if: AR/R channel plus the memory read port of the AXI slave read controller.
interface axi_slave_rd_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int ID_WIDTH = 4
);
  logic arvalid, arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [1:0] arburst;
  logic [ID_WIDTH-1:0] arid;
  logic rvalid, rready, rlast;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic [ID_WIDTH-1:0] rid;
  logic oen;
  logic [ADDR_WIDTH-1:0] add_rd;
  logic [DATA_WIDTH-1:0] dat_rd;
  modport master (
    output arvalid, araddr, arlen, arburst, arid, rready, dat_rd,
    input arready, rvalid, rdata, rresp, rlast, rid, oen, add_rd
  );
  modport slave (
    input arvalid, araddr, arlen, arburst, arid, rready, dat_rd,
    output arready, rvalid, rdata, rresp, rlast, rid, oen, add_rd
  );
endinterface

// File: rtl/axi_slave_rd_ctrl.sv
// axi_slave_rd_ctrl: AXI4 read controller, one burst at a time, 2-entry R buffer.
// WRAP bursts need AXI_RD_WRAP_EN; without it they are answered as SLVERR bursts.
module axi_slave_rd_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int ID_WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  axi_slave_rd_if.slave s
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic arready_q, ar_hs, err, issue, pop, wrap_ok, oen, rvalid;
  logic [1:0] burst, cnt, used;
  logic [7:0] left;
  logic [ADDR_WIDTH-1:0] addr, add_q, nxt_addr;
  logic [ID_WIDTH-1:0] id, inf_id;
  logic inf_v, inf_err, inf_last, wp, rp;
  logic [DATA_WIDTH-1:0] b_data [2];
  logic [1:0] b_resp [2];
  logic b_last [2];
  logic [ID_WIDTH-1:0] b_id [2];
`ifdef AXI_RD_WRAP_EN
  logic [ADDR_WIDTH-1:0] wmask;
  assign wrap_ok = s.arlen == 8'd1 || s.arlen == 8'd3 || s.arlen == 8'd7 || s.arlen == 8'd15;
  assign nxt_addr = burst == 2'b00 ? addr :
                    burst == 2'b10 ? (addr & ~wmask) | ((addr + ADDR_WIDTH'(1)) & wmask) :
                    addr + ADDR_WIDTH'(1);
`else
  assign wrap_ok = 1'b0;
  assign nxt_addr = burst == 2'b00 ? addr : addr + ADDR_WIDTH'(1);
`endif
  assign ar_hs = s.arvalid & arready_q;
  assign rvalid = cnt != 2'd0;
  assign pop = rvalid & s.rready;
  // The single read in flight plus buffered beats may never exceed the two buffer slots.
  assign used = cnt + {1'b0, inf_v};
  assign issue = state == BURST && (used < 2'd2 || pop);
  assign oen = issue & ~err;
  assign s.arready = arready_q;
  assign s.oen = oen;
  assign s.add_rd = oen ? addr : add_q;
  assign s.rvalid = rvalid;
  assign s.rdata = b_data[rp];
  assign s.rresp = b_resp[rp];
  assign s.rlast = b_last[rp];
  assign s.rid = b_id[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      arready_q <= 1'b0;
      err <= 1'b0;
      burst <= 2'b00;
      left <= 8'd0;
      addr <= '0;
      add_q <= '0;
      id <= '0;
`ifdef AXI_RD_WRAP_EN
      wmask <= '0;
`endif
    end else if (state == IDLE) begin
      arready_q <= ~ar_hs;
      if (ar_hs) begin
        state <= BURST;
        addr <= s.araddr;
        left <= s.arlen;
        burst <= s.arburst;
        id <= s.arid;
        err <= s.arburst == 2'b11 || (s.arburst == 2'b10 && !wrap_ok);
`ifdef AXI_RD_WRAP_EN
        wmask <= ADDR_WIDTH'(s.arlen);
`endif
      end
    end else if (issue) begin
      addr <= nxt_addr;
      left <= left - 8'd1;
      if (oen) add_q <= addr;
      if (left == 8'd0) begin
        state <= IDLE;
        arready_q <= 1'b1;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inf_v <= 1'b0;
      inf_err <= 1'b0;
      inf_last <= 1'b0;
      inf_id <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      b_data <= '{default: '0};
      b_resp <= '{default: '0};
      b_last <= '{default: '0};
      b_id <= '{default: '0};
    end else begin
      inf_v <= issue;
      inf_err <= err;
      inf_last <= left == 8'd0;
      inf_id <= id;
      if (inf_v) begin
        b_data[wp] <= inf_err ? '0 : s.dat_rd;
        b_resp[wp] <= inf_err ? 2'b10 : 2'b00;
        b_last[wp] <= inf_last;
        b_id[wp] <= inf_id;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, inf_v} - {1'b0, pop};
    end
endmodule

// File: tb/tb_axi_slave_rd_ctrl.sv
// tb_axi_slave_rd_ctrl: table vectors, corner sequences and random bursts against a beat-list model.
module tb_axi_slave_rd_ctrl;
  typedef struct packed {
    logic [63:0] d;
    logic [1:0] r;
    logic l;
    logic [3:0] id;
  } beat_t;
  typedef struct {
    logic [7:0] addr, len;
    logic [1:0] burst;
    logic [3:0] id;
    int mode;
    int oens;
    logic [7:0] first, last;
    logic [1:0] resp;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int cyc = 0, passed = 0, total = 0, mode = 0, phase = 0;
  int ok_out = 0, max_out = 0, mon_oens = 0, mon_beats = 0;
  bit mon_en = 1'b0, stall_prev = 1'b0;
  beat_t held;
  logic [7:0] mon_first, mon_last;
  logic [1:0] mon_resp;
  logic [7:0] exp_oens[$];
  beat_t exp_beats[$];
  vec_t vt [10];
  axi_slave_rd_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .ID_WIDTH(4)) bus ();
  axi_slave_rd_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .ID_WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] mem_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'd1, 24'hC0DE00, a};
  endfunction
  // Memory answers the cycle after oen; junk otherwise so error beats must really be zeroed.
  always @(posedge clk) bus.dat_rd <= bus.oen ? mem_word(bus.add_rd) : {$urandom, $urandom};
  always @(posedge clk) begin
    #1;
    phase = phase + 1;
    bus.rready = mode == 0 ? 1'b1 : mode == 1 ? (phase % 3 == 0) : ($urandom_range(0, 3) != 0);
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic void model_push(input logic [7:0] a, input logic [7:0] l,
                                     input logic [1:0] b, input logic [3:0] i);
    int n, base;
    bit e;
    logic [7:0] ad;
    n = int'(l) + 1;
    e = b == 2'b11 || (b == 2'b10 && n != 2 && n != 4 && n != 8 && n != 16);
`ifndef AXI_RD_WRAP_EN
    if (b == 2'b10) e = 1'b1;
`endif
    base = (int'(a) / n) * n;
    for (int k = 0; k < n; k++) begin
      ad = b == 2'b00 ? a : b == 2'b01 ? 8'((int'(a) + k) % 256) : 8'(base + (int'(a) - base + k) % n);
      if (!e) exp_oens.push_back(ad);
      exp_beats.push_back('{e ? 64'd0 : mem_word(ad), e ? 2'b10 : 2'b00, k == n - 1, i});
    end
  endfunction
  always @(negedge clk) begin
    if (!mon_en) begin
      stall_prev = 1'b0;
      ok_out = 0;
    end else begin
      if (stall_prev)
        chk("r_hold", 128'({bus.rvalid, bus.rdata, bus.rresp, bus.rlast, bus.rid}), 128'({1'b1, held}));
      if (bus.oen) begin
        if (mon_oens == 0) mon_first = bus.add_rd;
        mon_last = bus.add_rd;
        mon_oens++;
        ok_out++;
        if (exp_oens.size() == 0) chk("oen_unexpected", 128'(1), 128'(0));
        else chk("add_rd", 128'(bus.add_rd), 128'(exp_oens.pop_front()));
      end
      if (bus.rvalid && bus.rready) begin
        mon_beats++;
        mon_resp = bus.rresp;
        if (bus.rresp == 2'b00) ok_out--;
        if (exp_beats.size() == 0) chk("r_unexpected", 128'(1), 128'(0));
        else chk("r_beat", 128'({bus.rdata, bus.rresp, bus.rlast, bus.rid}), 128'(exp_beats.pop_front()));
      end
      if (ok_out > max_out) max_out = ok_out;
      stall_prev = bus.rvalid && !bus.rready;
      held = {bus.rdata, bus.rresp, bus.rlast, bus.rid};
    end
  end
  task automatic send_ar(input logic [7:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [3:0] i, output int hs_cyc);
    bit hs = 1'b0;
    int n = 0;
    bus.araddr = a;
    bus.arlen = l;
    bus.arburst = b;
    bus.arid = i;
    bus.arvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.arready;
      @(posedge clk);
      n++;
    end
    hs_cyc = cyc;
    #1;
    bus.arvalid = 1'b0;
    chk("ar_handshake", 128'(hs), 128'(1));
    if (hs) model_push(a, l, b, i);
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_beats.size() != 0 || exp_oens.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 128'(exp_beats.size() + exp_oens.size()), 128'(0));
    exp_beats.delete();
    exp_oens.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, 128'(bus.arready), 128'(0));
    chk({tag, "_rvalid"}, 128'(bus.rvalid), 128'(0));
    chk({tag, "_rdata"}, 128'(bus.rdata), 128'(0));
    chk({tag, "_rresp"}, 128'(bus.rresp), 128'(0));
    chk({tag, "_rlast"}, 128'(bus.rlast), 128'(0));
    chk({tag, "_rid"}, 128'(bus.rid), 128'(0));
    chk({tag, "_oen"}, 128'(bus.oen), 128'(0));
    chk({tag, "_add_rd"}, 128'(bus.add_rd), 128'(0));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int hs, h1, h2, stale, gap;
    logic [7:0] rl;
    logic [1:0] rb;
    vt[0] = '{8'h10, 8'd0, 2'b01, 4'd3, 0, 1, 8'h10, 8'h10, 2'b00};
    vt[1] = '{8'hFE, 8'd3, 2'b01, 4'd5, 0, 4, 8'hFE, 8'h01, 2'b00};
    vt[2] = '{8'h20, 8'd2, 2'b11, 4'd7, 0, 0, 8'h00, 8'h00, 2'b10};
    vt[3] = '{8'h30, 8'd2, 2'b10, 4'd8, 0, 0, 8'h00, 8'h00, 2'b10};
    vt[4] = '{8'h40, 8'd4, 2'b00, 4'd9, 2, 5, 8'h40, 8'h40, 2'b00};
    vt[5] = '{8'h00, 8'd7, 2'b01, 4'd11, 1, 8, 8'h00, 8'h07, 2'b00};
    vt[6] = '{8'h00, 8'd15, 2'b01, 4'd12, 2, 16, 8'h00, 8'h0F, 2'b00};
`ifdef AXI_RD_WRAP_EN
    vt[7] = '{8'h06, 8'd3, 2'b10, 4'd6, 0, 4, 8'h06, 8'h05, 2'b00};
    vt[8] = '{8'h0C, 8'd7, 2'b10, 4'd10, 1, 8, 8'h0C, 8'h0B, 2'b00};
    vt[9] = '{8'hF8, 8'd15, 2'b10, 4'd13, 2, 16, 8'hF8, 8'hF7, 2'b00};
`else
    vt[7] = '{8'h06, 8'd3, 2'b10, 4'd6, 0, 0, 8'h00, 8'h00, 2'b10};
    vt[8] = '{8'h0C, 8'd7, 2'b10, 4'd10, 1, 0, 8'h00, 8'h00, 2'b10};
    vt[9] = '{8'hF8, 8'd15, 2'b10, 4'd13, 2, 0, 8'h00, 8'h00, 2'b10};
`endif
    bus.arvalid = 1'b0;
    bus.araddr = 8'h00;
    bus.arlen = 8'h00;
    bus.arburst = 2'b00;
    bus.arid = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("arready_after_release", 128'(bus.arready), 128'(1));
    @(posedge clk);
    #1 mon_en = 1'b1;
    send_ar(8'h10, 8'd0, 2'b01, 4'd3, hs);
    @(negedge clk);
    chk("sb_c1_oen", 128'(bus.oen), 128'(1));
    chk("sb_c1_add_rd", 128'(bus.add_rd), 128'(8'h10));
    @(negedge clk);
    chk("sb_c2_rvalid", 128'(bus.rvalid), 128'(0));
    @(negedge clk);
    chk("sb_c3_rvalid", 128'(bus.rvalid), 128'(1));
    chk("sb_c3_rdata", 128'(bus.rdata), 128'(mem_word(8'h10)));
    chk("sb_c3_rresp", 128'(bus.rresp), 128'(0));
    chk("sb_c3_rlast", 128'(bus.rlast), 128'(1));
    chk("sb_c3_rid", 128'(bus.rid), 128'(3));
    drain();
    for (int v = 0; v < 10; v++) begin
      mode = vt[v].mode;
      mon_oens = 0;
      mon_beats = 0;
      mon_resp = 2'b00;
      send_ar(vt[v].addr, vt[v].len, vt[v].burst, vt[v].id, hs);
      drain();
      chk("tbl_oen_count", 128'(mon_oens), 128'(vt[v].oens));
      chk("tbl_beat_count", 128'(mon_beats), 128'(int'(vt[v].len) + 1));
      chk("tbl_resp", 128'(mon_resp), 128'(vt[v].resp));
      if (vt[v].oens != 0) begin
        chk("tbl_first_add", 128'(mon_first), 128'(vt[v].first));
        chk("tbl_last_add", 128'(mon_last), 128'(vt[v].last));
      end
    end
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_ar(8'h50, 8'd3, 2'b01, 4'd1, h1);
    send_ar(8'h60, 8'd3, 2'b01, 4'd2, h2);
    chk("b2b_accept_cycle", 128'(h2 - h1), 128'(5));
    drain();
    mode = 2;
    for (int k = 0; k < 40; k++) begin
      rb = 2'($urandom_range(0, 3));
      rl = $urandom_range(0, 2) == 0 ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
      send_ar(8'($urandom), rl, rb, 4'($urandom), hs);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk("credit_le_2", 128'(max_out <= 2), 128'(1));
    mode = 1;
    send_ar(8'h80, 8'd15, 2'b01, 4'hE, hs);
    repeat (8) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    exp_beats.delete();
    exp_oens.delete();
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      stale += int'(bus.rvalid | bus.oen);
    end
    chk("no_stale_beats", 128'(stale), 128'(0));
    chk("arready_after_midrst", 128'(bus.arready), 128'(1));
    @(posedge clk);
    #1;
    mode = 0;
    mon_en = 1'b1;
    send_ar(8'h33, 8'd1, 2'b01, 4'd2, hs);
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
